reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 139 +++++++++++++
 tb/tb_reset_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: releases NUM_STAGES reset domains one at a time, in order.
// All domains are held in reset for HOLD_CYCLES after reset removal. Each
// released domain must then acknowledge within ACK_TIMEOUT cycles. The next
// domain is released GAP_CYCLES after that acknowledge. A missing acknowledge
// puts every domain back into reset and raises a sticky timeout flag.
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int ACK_TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  sync_reset_i,
  input  logic                  soft_reset_i,
  input  logic [NUM_STAGES-1:0] stage_ack_i,
  output logic [NUM_STAGES-1:0] stage_reset_o,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic                  busy_o
);

  // One counter is shared by the hold, gap and ack-timeout phases. It is sized
  // for the longest of the three.
  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_ACK_WAIT,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_STAGES-1:0]   stage_reset_q;
  logic                    done_q;
  logic                    timeout_q;
  logic                    busy_q;

  logic [CNT_W-1:0]        cnt_inc_d;
  logic [IDX_W-1:0]        idx_inc_d;
  logic                    restart_d;

  // Incremented counter/index values and the combined restart request.
  always_comb begin
    cnt_inc_d = cnt_q + CNT_W'(1);
    idx_inc_d = idx_q + IDX_W'(1);
    restart_d = sync_reset_i | soft_reset_i;
  end

  // Sequencer FSM. All outputs are registered here alongside the state.
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the pre-edge values, so the order of statements does not matter.
  always_ff @(posedge clk) begin
    // NOTE: the synchronous reset is tested first. That gives it priority over
    // every FSM transition, so no stage can be released on an edge where reset
    // is sampled high.
    if (restart_d) begin
      state_q       <= S_HOLD;
      cnt_q         <= '0;
      idx_q         <= '0;
      stage_reset_q <= '1;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            stage_reset_q[0] <= 1'b0;
            idx_q            <= '0;
            cnt_q            <= '0;
            state_q          <= S_ACK_WAIT;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_ACK_WAIT: begin
          // An ack sampled on the final timeout edge still counts as success.
          if (stage_ack_i[idx_q]) begin
            if (idx_q == IDX_LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_GAP;
              cnt_q   <= '0;
            end
          end else if (cnt_q == ACK_LAST) begin
            state_q       <= S_ERROR;
            stage_reset_q <= '1;
            timeout_q     <= 1'b1;
            busy_q        <= 1'b0;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            stage_reset_q[idx_inc_d] <= 1'b0;
            idx_q                    <= idx_inc_d;
            cnt_q                    <= '0;
            state_q                  <= S_ACK_WAIT;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_DONE, S_ERROR: begin
          // Terminal states: only a reset or a soft reset leaves them.
        end
        default: begin
          state_q       <= S_HOLD;
          cnt_q         <= '0;
          idx_q         <= '0;
          stage_reset_q <= '1;
          done_q        <= 1'b0;
          timeout_q     <= 1'b0;
          busy_q        <= 1'b1;
        end
      endcase
    end
  end

  assign stage_reset_o = stage_reset_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer with NUM_STAGES=3, HOLD=4, GAP=2, TIMEOUT=8.
// It runs three parts:
//   - a table of per-edge vectors,
//   - hand-written corner-case sequences,
//   - randomized traffic compared against a release-count model.
module tb_reset_sequencer;

  localparam int N    = 3;
  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int TOUT = 8;

  logic         clk = 1'b0;
  logic         sync_reset = 1'b1;
  logic         soft_reset = 1'b0;
  logic [N-1:0] ack = '0;
  logic [N-1:0] stage_reset;
  logic         done, timeout, busy;

  int n_checks = 0;
  int n_errors = 0;

  reset_sequencer #(
    .NUM_STAGES (N),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .ACK_TIMEOUT(TOUT)
  ) dut (
    .clk          (clk),
    .sync_reset_i (sync_reset),
    .soft_reset_i (soft_reset),
    .stage_ack_i  (ack),
    .stage_reset_o(stage_reset),
    .done_o       (done),
    .timeout_o    (timeout),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // Reference model, described in terms of how many stages are released.
  //   m_t      counts edges spent in the current phase.
  //   m_acked  means the newest released stage has acknowledged (gap phase).
  int m_rel;
  int m_t;
  bit m_acked, m_fin, m_err;

  task automatic model_step(input bit s, input bit so, input logic [N-1:0] a);
    if (s || so) begin
      m_rel = 0; m_t = 0; m_acked = 0; m_fin = 0; m_err = 0;
    end else if (m_fin || m_err) begin
      // terminal
    end else if (m_rel == 0) begin
      m_t++;
      if (m_t == HOLD) begin m_rel = 1; m_t = 0; end
    end else if (!m_acked) begin
      if (a[m_rel-1]) begin
        if (m_rel == N) m_fin = 1;
        else begin m_acked = 1; m_t = 0; end
      end else begin
        m_t++;
        if (m_t == TOUT) m_err = 1;
      end
    end else begin
      m_t++;
      if (m_t == GAP) begin m_rel++; m_acked = 0; m_t = 0; end
    end
  endtask

  function automatic logic [5:0] model_out();
    logic [N-1:0] sr;
    sr = m_err ? '1 : N'(~((1 << m_rel) - 1));
    return {sr, m_fin, m_err, !(m_fin || m_err)};
  endfunction

  function automatic logic [5:0] dut_out();
    return {stage_reset, done, timeout, busy};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got {sr,done,tout,busy}=%b_%b_%b_%b expected %b_%b_%b_%b",
               name, act[5:3], act[2], act[1], act[0], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic chk(input string name, input logic [N-1:0] sr, input bit d, input bit t,
                     input bit b);
    check(name, dut_out(), {sr, d, t, b});
  endtask

  // Drive inputs on the falling edge, let the rising edge act, sample 1 ns later.
  task automatic step(input bit s, input bit so, input logic [N-1:0] a);
    @(negedge clk);
    sync_reset = s; soft_reset = so; ack = a;
    @(posedge clk);
    model_step(s, so, a);
    #1;
  endtask

  typedef struct {
    bit           s;
    bit           so;
    logic [N-1:0] a;
    logic [N-1:0] sr;
    bit           d;
    bit           t;
    bit           b;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Acks tied high: releases at E4/E7/E10, done at E11, then a soft reset.
    tbl[0]  = '{1, 0, 3'b111, 3'b111, 0, 0, 1};  // E0 reset edge
    tbl[1]  = '{0, 0, 3'b111, 3'b111, 0, 0, 1};  // E1
    tbl[2]  = '{0, 0, 3'b111, 3'b111, 0, 0, 1};
    tbl[3]  = '{0, 0, 3'b111, 3'b111, 0, 0, 1};
    tbl[4]  = '{0, 0, 3'b111, 3'b110, 0, 0, 1};  // E4
    tbl[5]  = '{0, 0, 3'b111, 3'b110, 0, 0, 1};
    tbl[6]  = '{0, 0, 3'b111, 3'b110, 0, 0, 1};
    tbl[7]  = '{0, 0, 3'b111, 3'b100, 0, 0, 1};  // E7
    tbl[8]  = '{0, 0, 3'b111, 3'b100, 0, 0, 1};
    tbl[9]  = '{0, 0, 3'b111, 3'b100, 0, 0, 1};
    tbl[10] = '{0, 0, 3'b111, 3'b000, 0, 0, 1};  // E10
    tbl[11] = '{0, 0, 3'b111, 3'b000, 1, 0, 0};  // E11 done
    tbl[12] = '{0, 0, 3'b000, 3'b000, 1, 0, 0};  // acks dropped: ignored
    tbl[13] = '{0, 1, 3'b111, 3'b111, 0, 0, 1};  // soft reset from DONE
    tbl[14] = '{1, 1, 3'b111, 3'b111, 0, 0, 1};  // both high = reset

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].s, tbl[i].so, tbl[i].a);
      check($sformatf("table[%0d]", i), dut_out(),
            {tbl[i].sr, tbl[i].d, tbl[i].t, tbl[i].b});
    end

    // Acks held low: stage 0 released at E4, ERROR at E12, then it stays there.
    step(1, 0, 3'b000);
    for (int e = 1; e <= 20; e++) begin
      step(0, 0, 3'b000);
      if (e == 4)  chk("tout_rel0_e4", 3'b110, 0, 0, 1);
      if (e == 11) chk("tout_e11_still_wait", 3'b110, 0, 0, 1);
      if (e == 12) chk("tout_error_e12", 3'b111, 0, 1, 0);
      if (e == 20) chk("tout_sticky_e20", 3'b111, 0, 1, 0);
    end

    // One-cycle soft reset from ERROR with acks high repeats the normal timing.
    step(0, 1, 3'b111);
    chk("soft_clear_timeout", 3'b111, 0, 0, 1);
    for (int e = 1; e <= 11; e++) begin
      step(0, 0, 3'b111);
      if (e == 3)  chk("soft_e3_hold", 3'b111, 0, 0, 1);
      if (e == 4)  chk("soft_e4", 3'b110, 0, 0, 1);
      if (e == 7)  chk("soft_e7", 3'b100, 0, 0, 1);
      if (e == 10) chk("soft_e10", 3'b000, 0, 0, 1);
      if (e == 11) chk("soft_e11_done", 3'b000, 1, 0, 0);
    end

    // A sync reset during GAP reasserts every stage and restarts a full HOLD.
    step(1, 0, 3'b111);
    for (int e = 1; e <= 5; e++) step(0, 0, 3'b111);
    chk("gap_pre_reset", 3'b110, 0, 0, 1);
    step(1, 0, 3'b111);
    chk("gap_reset_edge", 3'b111, 0, 0, 1);
    for (int e = 1; e <= 4; e++) begin
      step(0, 0, 3'b111);
      if (e == 3) chk("gap_rehold_e3", 3'b111, 0, 0, 1);
      if (e == 4) chk("gap_rehold_e4", 3'b110, 0, 0, 1);
    end

    // Early acks on stages 1 and 2 must not cause an early release.
    step(1, 0, 3'b110);
    for (int e = 1; e <= 15; e++) begin
      step(0, 0, (e >= 9) ? 3'b111 : 3'b110);
      if (e == 8)  chk("early_e8_no_release", 3'b110, 0, 0, 1);
      if (e == 10) chk("early_e10_gap", 3'b110, 0, 0, 1);
      if (e == 11) chk("early_e11_rel1", 3'b100, 0, 0, 1);
      if (e == 14) chk("early_e14_rel2", 3'b000, 0, 0, 1);
      if (e == 15) chk("early_e15_done", 3'b000, 1, 0, 0);
    end

    // An ack arriving on the last timeout edge (E12) wins over the timeout.
    step(1, 0, 3'b000);
    for (int e = 1; e <= 14; e++) begin
      step(0, 0, (e >= 12) ? 3'b001 : 3'b000);
      if (e == 12) chk("lastack_e12_no_err", 3'b110, 0, 0, 1);
      if (e == 14) chk("lastack_e14_rel1", 3'b100, 0, 0, 1);
    end

    // Randomized traffic compared against the model on every edge.
    step(1, 0, 3'b000);
    check("rand_start", dut_out(), model_out());
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] a;
      bit s, so;
      for (int k = 0; k < N; k++) a[k] = ($urandom_range(0, 99) < 30);
      s  = ($urandom_range(0, 299) == 0);
      so = ($urandom_range(0, 99) == 0);
      step(s, so, a);
      check($sformatf("rand[%0d]", c), dut_out(), model_out());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
